ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-requester arbiter that time-shares one synchronous single-read/single-write RAM (1-cycle registered read).
- Requester A is the instruction-fetch side of the mini-risc16 core; requester B is the load/store side.
- Issues at most one access per cycle and returns read data to the issuer one cycle later.
- Burst-limited round-robin ownership keeps either side from starving the other.

Parameters:
- WORD_WIDTH, 16, data width of RAM and requesters
- ADDR_WIDTH, 8, address width
- MAX_BURST, 4, maximum consecutive grants to the current owner while the other side is requesting (>=1; 1 = strict alternation)

Ports:
- gclk  in  1  clock, all state on rising edge
- nreset  in  1  asynchronous active-low reset
- a_req  in  1  A requests an access; held until a_ack
- a_we  in  1  A access is a write
- a_addr  in  ADDR_WIDTH  A address
- a_wdata  in  WORD_WIDTH  A write data
- a_ack  out  1  A access accepted this cycle (combinational)
- a_rvalid  out  1  a_rdata valid (registered)
- a_rdata  out  WORD_WIDTH  A read data
- b_req, b_we, b_addr, b_wdata, b_ack, b_rvalid, b_rdata: same as A, for B
- ram_ReadAddr  out  ADDR_WIDTH  to RAM ReadAddr
- ram_WriteAddr  out  ADDR_WIDTH  to RAM WriteAddr
- ram_WriteData  out  WORD_WIDTH  to RAM WriteData
- ram_WriteEnable  out  1  to RAM WriteEnable
- ram_ReadData  in  WORD_WIDTH  from RAM ReadData

Behaviour:
- Handshake: a transfer occurs on a rising edge where req && ack. Requester holds we/addr/wdata stable while req && !ack. At most one of a_ack/b_ack is high in any cycle.
- Acks are combinational from req and registered state only. No path from ram_ReadData to ack.
- Muxing: the granted side drives ram_ReadAddr/ram_WriteAddr (both = its addr) and ram_WriteData. ram_WriteEnable = granted && we. With no grant, ram_WriteEnable=0 and addresses/data hold the A-side values.
- Read latency: grant of a read at edge N gives x_rvalid=1 during cycle N+1, with x_rdata = ram_ReadData. x_rdata is a passthrough and is meaningful only while x_rvalid. Writes never assert rvalid.
- Back-to-back reads pipeline: one grant per cycle, one rvalid per cycle.
- State: owner in {IDLE, OWN_A, OWN_B}, last in {A,B}, burst_cnt (clog2(MAX_BURST+1) bits, saturating).
- IDLE:
  - only A requests -> grant A, go to OWN_A, burst_cnt=1.
  - only B requests -> symmetric.
  - both request -> grant the side != last, go to its OWN state.
- OWN_X, X requesting, other idle -> grant X; burst_cnt increments, saturating at MAX_BURST.
- OWN_X, both requesting:
  - burst_cnt < MAX_BURST -> grant X, burst_cnt++.
  - otherwise -> grant the other side, owner switches, burst_cnt=1, last=X.
- OWN_X, X not requesting, other requesting -> grant other, switch, burst_cnt=1, last=X.
- OWN_X, neither requesting -> IDLE, last=X, burst_cnt=0.
- Worst-case wait for a held request is MAX_BURST cycles.
- Reset (async, nreset=0):
  - owner=IDLE, last=B (so A wins the first tie), burst_cnt=0.
  - a_rvalid=b_rvalid=0; acks=0 and ram_WriteEnable=0 while in reset.
  - A read granted on the edge before reset assertion produces no rvalid after release.
- Same-address A write and B read in consecutive cycles: the read sees the new data (RAM ordering). Same-cycle conflict is impossible by construction.

Test Plan:
- Reset release, a_req=1 a_we=0 a_addr=0x10 (RAM[0x10]=0x1234) -> a_ack at the first edge, a_rvalid=1 with a_rdata=0x1234 the next cycle; b_rvalid stays 0.
- Preload RAM, MAX_BURST=4, A and B read continuously from cycle 0 -> grants A,A,A,A,B,B,B,B,A...; every rvalid is routed to the issuer with the correct data, one per cycle.
- MAX_BURST=1, both requesting -> strict A,B,A,B alternation; A first after reset.
- B writes 0xBEEF to 0x20, then A reads 0x20 on the next grant -> a_rdata=0xBEEF; ram_WriteEnable high only in B's grant cycle.
- A alone for 10 cycles, then B asserts -> B acked within ≤1 cycle (burst_cnt saturated at 4); A re-acked after B's burst.
- nreset pulsed low during an in-flight A read -> a_rvalid=0 immediately and stays 0 after release; owner=IDLE; next tie goes to A.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-requester arbiter time-sharing one synchronous RAM (registered 1-cycle read).
// Burst-limited round-robin ownership between fetch side (A) and load/store side (B).
module ram_arbiter #(
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                  gclk,
  input  logic                  nreset,
  // Handshake: a transfer happens on a rising edge where req && ack; while
  // req && !ack the requester holds we/addr/wdata stable. Ack depends only on
  // req and registered state, and at most one ack is high per cycle.
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [WORD_WIDTH-1:0] a_wdata,
  output logic                  a_ack,
  output logic                  a_rvalid,
  output logic [WORD_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [WORD_WIDTH-1:0] b_wdata,
  output logic                  b_ack,
  output logic                  b_rvalid,
  output logic [WORD_WIDTH-1:0] b_rdata,
  output logic [ADDR_WIDTH-1:0] ram_ReadAddr,
  output logic [ADDR_WIDTH-1:0] ram_WriteAddr,
  output logic [WORD_WIDTH-1:0] ram_WriteData,
  output logic                  ram_WriteEnable,
  input  logic [WORD_WIDTH-1:0] ram_ReadData,
  output logic [1:0]            dbg_owner,
  output logic                  dbg_last,
  output logic [CNT_W-1:0]      dbg_burst_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN_A = 2'd1, OWN_B = 2'd2} owner_t;
  typedef enum logic {SIDE_A = 1'b0, SIDE_B = 1'b1} side_t;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  owner_t            owner, owner_d;
  side_t             last, last_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              grant_a, grant_b;

  always_ff @(posedge gclk or negedge nreset) begin
    if (!nreset) begin
      owner    <= IDLE;
      last     <= SIDE_B;
      cnt      <= '0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      owner    <= owner_d;
      last     <= last_d;
      cnt      <= cnt_d;
      a_rvalid <= a_ack && !a_we;
      b_rvalid <= b_ack && !b_we;
    end
  end

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    owner_d = owner;
    last_d  = last;
    cnt_d   = cnt;
    unique case (owner)
      IDLE: begin
        // Tie goes to the side that was not served last.
        if (a_req && (!b_req || last == SIDE_B)) begin
          grant_a = 1'b1;
          owner_d = OWN_A;
          cnt_d   = ONE_C;
        end else if (b_req) begin
          grant_b = 1'b1;
          owner_d = OWN_B;
          cnt_d   = ONE_C;
        end
      end
      OWN_A: begin
        if (a_req && (!b_req || cnt < MAX_C)) begin
          grant_a = 1'b1;
          if (cnt < MAX_C) cnt_d = cnt + ONE_C;
        end else if (b_req) begin
          grant_b = 1'b1;
          owner_d = OWN_B;
          cnt_d   = ONE_C;
          last_d  = SIDE_A;
        end else begin
          owner_d = IDLE;
          cnt_d   = '0;
          last_d  = SIDE_A;
        end
      end
      OWN_B: begin
        if (b_req && (!a_req || cnt < MAX_C)) begin
          grant_b = 1'b1;
          if (cnt < MAX_C) cnt_d = cnt + ONE_C;
        end else if (a_req) begin
          grant_a = 1'b1;
          owner_d = OWN_A;
          cnt_d   = ONE_C;
          last_d  = SIDE_B;
        end else begin
          owner_d = IDLE;
          cnt_d   = '0;
          last_d  = SIDE_B;
        end
      end
      default: owner_d = IDLE;
    endcase
  end

  // Gating with nreset keeps acks and writes quiet while reset is held.
  assign a_ack = grant_a && nreset;
  assign b_ack = grant_b && nreset;

  assign ram_ReadAddr    = b_ack ? b_addr : a_addr;
  assign ram_WriteAddr   = b_ack ? b_addr : a_addr;
  assign ram_WriteData   = b_ack ? b_wdata : a_wdata;
  assign ram_WriteEnable = (a_ack && a_we) || (b_ack && b_we);

  assign a_rdata = ram_ReadData;
  assign b_rdata = ram_ReadData;

  assign dbg_owner     = owner;
  assign dbg_last      = last;
  assign dbg_burst_cnt = cnt;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: table-driven vectors on a MAX_BURST=4 instance plus a
// hand-written alternation sequence on a MAX_BURST=1 instance, each with its own RAM.
module tb_ram_arbiter;

  logic        gclk;
  logic        nreset;
  logic        a_req, a_we, b_req, b_we;
  logic [7:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;

  // instance 0 (MAX_BURST=4)
  logic        a_ack0, b_ack0, a_rv0, b_rv0, we0, last0;
  logic [15:0] a_rd0, b_rd0, wd0, rd0;
  logic [7:0]  ra0, wa0;
  logic [1:0]  own0;
  logic [2:0]  cnt0;
  logic [15:0] mem0 [256];

  // instance 1 (MAX_BURST=1)
  logic        a_ack1, b_ack1, a_rv1, b_rv1, we1, last1;
  logic [15:0] a_rd1, b_rd1, wd1, rd1;
  logic [7:0]  ra1, wa1;
  logic [1:0]  own1;
  logic [0:0]  cnt1;
  logic [15:0] mem1 [256];

  int n_cmp = 0;
  int n_bad = 0;
  logic [16:0] exp_q[$];

  // clock / reset
  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  ram_arbiter #(.WORD_WIDTH(16), .ADDR_WIDTH(8), .MAX_BURST(4)) dut0 (
    .gclk(gclk), .nreset(nreset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack0), .a_rvalid(a_rv0), .a_rdata(a_rd0),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack0), .b_rvalid(b_rv0), .b_rdata(b_rd0),
    .ram_ReadAddr(ra0), .ram_WriteAddr(wa0), .ram_WriteData(wd0),
    .ram_WriteEnable(we0), .ram_ReadData(rd0),
    .dbg_owner(own0), .dbg_last(last0), .dbg_burst_cnt(cnt0)
  );

  ram_arbiter #(.WORD_WIDTH(16), .ADDR_WIDTH(8), .MAX_BURST(1)) dut1 (
    .gclk(gclk), .nreset(nreset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack1), .a_rvalid(a_rv1), .a_rdata(a_rd1),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack1), .b_rvalid(b_rv1), .b_rdata(b_rd1),
    .ram_ReadAddr(ra1), .ram_WriteAddr(wa1), .ram_WriteData(wd1),
    .ram_WriteEnable(we1), .ram_ReadData(rd1),
    .dbg_owner(own1), .dbg_last(last1), .dbg_burst_cnt(cnt1)
  );

  // RAM models: registered read, synchronous write
  always @(posedge gclk) begin
    if (we0) mem0[wa0] <= wd0;
    rd0 <= mem0[ra0];
    if (we1) mem1[wa1] <= wd1;
    rd1 <= mem1[ra1];
  end

  typedef struct {
    logic        rst;
    logic        a_req, a_we;
    logic [7:0]  a_addr;
    logic [15:0] a_wdata;
    logic        b_req, b_we;
    logic [7:0]  b_addr;
    logic [15:0] b_wdata;
    logic [3:0]  flags;   // {a_ack, b_ack, a_rvalid, b_rvalid}
    logic [15:0] rdata;
    logic        we;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic ar, logic aw, logic [7:0] aa, logic [15:0] ad,
                              logic br, logic bw, logic [7:0] ba, logic [15:0] bd,
                              logic [3:0] fl, logic [15:0] rd, logic we);
    vec_t v;
    v.rst = rst; v.a_req = ar; v.a_we = aw; v.a_addr = aa; v.a_wdata = ad;
    v.b_req = br; v.b_we = bw; v.b_addr = ba; v.b_wdata = bd;
    v.flags = fl; v.rdata = rd; v.we = we;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic ar, input logic aw, input logic [7:0] aa,
                       input logic [15:0] ad, input logic br, input logic bw,
                       input logic [7:0] ba, input logic [15:0] bd);
    @(negedge gclk);
    nreset = !rst;
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    #1;
  endtask

  initial begin
    nreset = 1'b0;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 16'h1000 + 16'(i);
      mem1[i] = 16'h1000 + 16'(i);
    end
    mem0[8'h10] = 16'h1234;
    mem1[8'h10] = 16'h1234;

    // single A read after reset
    tbl.push_back(mk(1, 1,0,8'h10,0, 0,0,0,0, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 1,0,8'h10,0, 0,0,0,0, 4'b1000, 0, 0));
    tbl.push_back(mk(0, 0,0,0,0,     0,0,0,0, 4'b0010, 16'h1234, 0));
    tbl.push_back(mk(0, 0,0,0,0,     0,0,0,0, 4'b0000, 0, 0));
    // both reading continuously: A x4 then B x4 then A
    tbl.push_back(mk(1, 1,0,8'h01,0, 1,0,8'h81,0, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 1,0,8'h01,0, 1,0,8'h81,0, 4'b1000, 0, 0));
    tbl.push_back(mk(0, 1,0,8'h02,0, 1,0,8'h81,0, 4'b1010, 16'h1001, 0));
    tbl.push_back(mk(0, 1,0,8'h03,0, 1,0,8'h81,0, 4'b1010, 16'h1002, 0));
    tbl.push_back(mk(0, 1,0,8'h04,0, 1,0,8'h81,0, 4'b1010, 16'h1003, 0));
    tbl.push_back(mk(0, 1,0,8'h05,0, 1,0,8'h81,0, 4'b0110, 16'h1004, 0));
    tbl.push_back(mk(0, 1,0,8'h05,0, 1,0,8'h82,0, 4'b0101, 16'h1081, 0));
    tbl.push_back(mk(0, 1,0,8'h05,0, 1,0,8'h83,0, 4'b0101, 16'h1082, 0));
    tbl.push_back(mk(0, 1,0,8'h05,0, 1,0,8'h84,0, 4'b0101, 16'h1083, 0));
    tbl.push_back(mk(0, 1,0,8'h05,0, 1,0,8'h85,0, 4'b1001, 16'h1084, 0));
    tbl.push_back(mk(0, 1,0,8'h06,0, 1,0,8'h85,0, 4'b1010, 16'h1005, 0));
    tbl.push_back(mk(0, 0,0,0,0,     1,0,8'h85,0, 4'b0110, 16'h1006, 0));
    tbl.push_back(mk(0, 0,0,0,0,     0,0,0,0,     4'b0001, 16'h1085, 0));
    // B writes BEEF to 0x20, A reads it back next
    tbl.push_back(mk(0, 0,0,0,0,     1,1,8'h20,16'hBEEF, 4'b0100, 0, 1));
    tbl.push_back(mk(0, 1,0,8'h20,0, 0,0,0,0, 4'b1000, 0, 0));
    tbl.push_back(mk(0, 0,0,0,0,     0,0,0,0, 4'b0010, 16'hBEEF, 0));
    // A alone 10 cycles, then B arrives with burst_cnt saturated
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk(0, 1,0,8'h30 + 8'(k),0, 0,0,0,0, (k == 0) ? 4'b1000 : 4'b1010,
                       16'h1030 + 16'(k) - 16'h1, 0));
    tbl.push_back(mk(0, 1,0,8'h3A,0, 1,0,8'h90,0, 4'b0110, 16'h1039, 0));
    tbl.push_back(mk(0, 1,0,8'h3A,0, 1,0,8'h91,0, 4'b0101, 16'h1090, 0));
    tbl.push_back(mk(0, 1,0,8'h3A,0, 1,0,8'h92,0, 4'b0101, 16'h1091, 0));
    tbl.push_back(mk(0, 1,0,8'h3A,0, 1,0,8'h93,0, 4'b0101, 16'h1092, 0));
    tbl.push_back(mk(0, 1,0,8'h3A,0, 1,0,8'h94,0, 4'b1001, 16'h1093, 0));
    tbl.push_back(mk(0, 0,0,0,0,     1,0,8'h94,0, 4'b0110, 16'h103A, 0));
    tbl.push_back(mk(0, 0,0,0,0,     0,0,0,0,     4'b0001, 16'h1094, 0));
    // leave last=A, then reset during an in-flight A read; tie must go to A
    tbl.push_back(mk(0, 1,0,8'h10,0, 0,0,0,0, 4'b1000, 0, 0));
    tbl.push_back(mk(0, 0,0,0,0,     0,0,0,0, 4'b0010, 16'h1234, 0));
    tbl.push_back(mk(0, 1,0,8'h11,0, 0,0,0,0, 4'b1000, 0, 0));
    tbl.push_back(mk(1, 0,0,0,0,     0,0,0,0, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 0,0,0,0,     0,0,0,0, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 1,0,8'h11,0, 1,0,8'h12,0, 4'b1000, 0, 0));
    tbl.push_back(mk(0, 0,0,0,0,     1,0,8'h12,0, 4'b0110, 16'h1011, 0));
    tbl.push_back(mk(0, 0,0,0,0,     0,0,0,0,     4'b0001, 16'h1012, 0));
    tbl.push_back(mk(0, 0,0,0,0,     0,0,0,0,     4'b0000, 0, 0));

    foreach (tbl[i]) begin
      vec_t v;
      v = tbl[i];
      drive(v.rst, v.a_req, v.a_we, v.a_addr, v.a_wdata, v.b_req, v.b_we, v.b_addr, v.b_wdata);
      chk($sformatf("v%0d a_ack", i),    32'(a_ack0), 32'(v.flags[3]));
      chk($sformatf("v%0d b_ack", i),    32'(b_ack0), 32'(v.flags[2]));
      chk($sformatf("v%0d a_rvalid", i), 32'(a_rv0),  32'(v.flags[1]));
      chk($sformatf("v%0d b_rvalid", i), 32'(b_rv0),  32'(v.flags[0]));
      chk($sformatf("v%0d ram_we", i),   32'(we0),    32'(v.we));
      if (v.flags[1]) chk($sformatf("v%0d a_rdata", i), 32'(a_rd0), 32'(v.rdata));
      if (v.flags[0]) chk($sformatf("v%0d b_rdata", i), 32'(b_rd0), 32'(v.rdata));
      if (v.we) begin
        chk($sformatf("v%0d ram_waddr", i), 32'(wa0), 32'(v.b_addr));
        chk($sformatf("v%0d ram_wdata", i), 32'(wd0), 32'(v.b_wdata));
      end
      if (v.rst) begin
        chk($sformatf("v%0d owner", i), 32'(own0), 32'd0);
        chk($sformatf("v%0d burst", i), 32'(cnt0), 32'd0);
      end
    end

    // MAX_BURST=1: strict alternation, A first after reset
    drive(1, 0,0,0,0, 0,0,0,0);
    chk("alt reset owner", 32'(own1), 32'd0);
    chk("alt reset last",  32'(last1), 32'd1);
    for (int i = 0; i < 9; i++) begin
      logic ea, eb;
      logic [16:0] e;
      drive(0, (i < 7), 0, 8'h40, 0, (i < 8), 0, 8'h50, 0);
      ea = (i < 8) && (i % 2 == 0);
      eb = (i < 8) && (i % 2 == 1);
      chk($sformatf("alt%0d a_ack", i), 32'(a_ack1), 32'(ea));
      chk($sformatf("alt%0d b_ack", i), 32'(b_ack1), 32'(eb));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk($sformatf("alt%0d a_rvalid", i), 32'(a_rv1), 32'(!e[16]));
        chk($sformatf("alt%0d b_rvalid", i), 32'(b_rv1), 32'(e[16]));
        chk($sformatf("alt%0d rdata", i), 32'(e[16] ? b_rd1 : a_rd1), 32'(e[15:0]));
      end else begin
        chk($sformatf("alt%0d rvalid idle", i), 32'({a_rv1, b_rv1}), 32'd0);
      end
      if (ea) exp_q.push_back({1'b0, 16'h1040});
      if (eb) exp_q.push_back({1'b1, 16'h1050});
    end
    chk("alt queue drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
